// File: rtl/wb_stage.sv
// wb_stage: writeback arbiter between ALU results and buffered load returns, driving the register file write port
module wb_stage #(
    parameter int  WORD_WIDTH     = 32,
    parameter int  REG_ADDR_WIDTH = 5,
    localparam int NREGS          = 1 << REG_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      alu_valid,
    input  logic [REG_ADDR_WIDTH-1:0] alu_rd,
    input  logic [WORD_WIDTH-1:0]     alu_data,
    output logic                      alu_ready,
    input  logic                      ld_valid,
    input  logic [REG_ADDR_WIDTH-1:0] ld_rd,
    input  logic [WORD_WIDTH-1:0]     ld_data,
    output logic                      ld_ready,
    output logic                      w_en,
    output logic [REG_ADDR_WIDTH-1:0] wa3,
    output logic [WORD_WIDTH-1:0]     wd3,
    output logic                      byp_valid,
    output logic [REG_ADDR_WIDTH-1:0] byp_addr,
    output logic [WORD_WIDTH-1:0]     byp_data,
    output logic [NREGS-1:0]          pend_mask
);
    logic [REG_ADDR_WIDTH-1:0] fifo_rd   [2];
    logic [WORD_WIDTH-1:0]     fifo_data [2];
    logic [1:0]                count;
    logic                      head;
    logic                      full;
    logic                      push;
    logic                      pop;
    logic                      sel;
    logic [REG_ADDR_WIDTH-1:0] sel_rd;
    logic [WORD_WIDTH-1:0]     sel_data;

    // A full FIFO drains first; otherwise the ALU wins and buffered loads fill idle slots
    always_comb begin
        full      = count == 2'd2;
        ld_ready  = !full;
        alu_ready = !full;
        push      = ld_valid && !full;
        pop       = full || (!alu_valid && count != 2'd0);
        sel       = pop || (alu_valid && !full);
        sel_rd    = pop ? fifo_rd[head] : alu_rd;
        sel_data  = pop ? fifo_data[head] : alu_data;
    end

    // Load storage is left unreset; entries are only observed while counted valid
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[head ^ count[0]]   <= ld_rd;
            fifo_data[head ^ count[0]] <= ld_data;
        end
    end

    // Queue bookkeeping, registered write port and the one-cycle bypass copy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= 2'd0;
            head      <= 1'b0;
            w_en      <= 1'b0;
            wa3       <= '0;
            wd3       <= '0;
            byp_valid <= 1'b0;
            byp_addr  <= '0;
            byp_data  <= '0;
        end else begin
            count     <= count + {1'b0, push} - {1'b0, pop};
            head      <= head ^ pop;
            w_en      <= sel && sel_rd != '0;
            if (sel) begin
                wa3 <= sel_rd;
                wd3 <= sel_data;
            end
            byp_valid <= w_en;
            byp_addr  <= wa3;
            byp_data  <= wd3;
        end
    end

    // Registers with a write accepted but not yet committed; x0 never counts
    always_comb begin
        pend_mask = '0;
        if (count != 2'd0) pend_mask[fifo_rd[head]] = 1'b1;
        if (full) pend_mask[fifo_rd[~head]] = 1'b1;
        if (w_en) pend_mask[wa3] = 1'b1;
        pend_mask[0] = 1'b0;
    end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed and randomized checks of wb_stage against a queue-based writeback model
module tb_wb_stage;
    localparam int WW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    typedef struct {
        logic [AW-1:0] rd;
        logic [WW-1:0] d;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          alu_valid = 1'b0;
    logic [AW-1:0] alu_rd = '0;
    logic [WW-1:0] alu_data = '0;
    logic          alu_ready;
    logic          ld_valid = 1'b0;
    logic [AW-1:0] ld_rd = '0;
    logic [WW-1:0] ld_data = '0;
    logic          ld_ready;
    logic          w_en;
    logic [AW-1:0] wa3;
    logic [WW-1:0] wd3;
    logic          byp_valid;
    logic [AW-1:0] byp_addr;
    logic [WW-1:0] byp_data;
    logic [NR-1:0] pend_mask;

    int n_cmp = 0;
    int n_err = 0;

    ent_t          q[$];
    logic          m_wen;
    logic [AW-1:0] m_wa;
    logic [WW-1:0] m_wd;
    logic          m_bv;
    logic [AW-1:0] m_ba;
    logic [WW-1:0] m_bd;

    always #5 clk = ~clk;

    wb_stage #(.WORD_WIDTH(WW), .REG_ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
        .w_en(w_en), .wa3(wa3), .wd3(wd3),
        .byp_valid(byp_valid), .byp_addr(byp_addr), .byp_data(byp_data),
        .pend_mask(pend_mask)
    );

    task automatic model_reset();
        q.delete();
        m_wen = 1'b0; m_wa = '0; m_wd = '0;
        m_bv = 1'b0; m_ba = '0; m_bd = '0;
    endtask

    function automatic logic [NR-1:0] m_pend();
        logic [NR-1:0] p;
        p = '0;
        foreach (q[i]) p[q[i].rd] = 1'b1;
        if (m_wen) p[m_wa] = 1'b1;
        p[0] = 1'b0;
        return p;
    endfunction

    // Advance the model by one edge using the current inputs, then step the DUT and settle
    task automatic tick();
        ent_t e;
        bit   push;
        bit   got;
        push = ld_valid && q.size() < 2;
        m_bv = m_wen; m_ba = m_wa; m_bd = m_wd;
        got = 1'b1;
        if (q.size() == 2) e = q.pop_front();
        else if (alu_valid) begin e.rd = alu_rd; e.d = alu_data; end
        else if (q.size() > 0) e = q.pop_front();
        else got = 1'b0;
        m_wen = got && e.rd != 0;
        if (got) begin m_wa = e.rd; m_wd = e.d; end
        if (push) begin
            ent_t n;
            n.rd = ld_rd; n.d = ld_data;
            q.push_back(n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        alu_valid = 1'b0; ld_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        n_cmp++; if (w_en !== 1'b0) begin n_err++; $display("FAIL reset_w_en got %b want 0", w_en); end
        n_cmp++; if (pend_mask !== '0) begin n_err++; $display("FAIL reset_pend got %h want 0", pend_mask); end
        n_cmp++; if (ld_ready !== 1'b1) begin n_err++; $display("FAIL reset_ld_ready got %b want 1", ld_ready); end
        n_cmp++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL reset_alu_ready got %b want 1", alu_ready); end
        n_cmp++; if (byp_valid !== 1'b0 || wa3 !== '0 || wd3 !== '0) begin n_err++; $display("FAIL reset_regs got byp_valid=%b wa3=%0d wd3=%h want 0/0/0", byp_valid, wa3, wd3); end
        #2 rst_n = 1'b1;
        tick();
        alu_valid = 1'b0;
        n_cmp++; if (w_en !== 1'b1 || wa3 !== 5'd3) begin n_err++; $display("FAIL reset_release_write got w_en=%b wa3=%0d want 1/3", w_en, wa3); end
    endtask

    task automatic test_alu_write();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        tick();
        alu_valid = 1'b0;
        n_cmp++; if (w_en !== 1'b1 || wa3 !== 5'd5 || wd3 !== 32'hDEADBEEF) begin n_err++; $display("FAIL alu_out got %b/%0d/%h want 1/5/deadbeef", w_en, wa3, wd3); end
        n_cmp++; if (pend_mask[5] !== 1'b1) begin n_err++; $display("FAIL alu_pend_n1 got %b want 1", pend_mask[5]); end
        tick();
        n_cmp++; if (byp_valid !== 1'b1 || byp_addr !== 5'd5 || byp_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL alu_byp got %b/%0d/%h want 1/5/deadbeef", byp_valid, byp_addr, byp_data); end
        n_cmp++; if (pend_mask[5] !== 1'b0 || w_en !== 1'b0) begin n_err++; $display("FAIL alu_pend_n2 got pend=%b w_en=%b want 0/0", pend_mask[5], w_en); end
    endtask

    task automatic test_contention();
        logic [AW-1:0] got[$];
        logic [AW-1:0] want[5];
        want[0] = 5'd1; want[1] = 5'd2; want[2] = 5'd7; want[3] = 5'd3; want[4] = 5'd8;
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA1; ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'hB7;
        tick(); if (w_en) got.push_back(wa3);
        alu_rd = 5'd2; alu_data = 32'hA2; ld_rd = 5'd8; ld_data = 32'hB8;
        tick(); if (w_en) got.push_back(wa3);
        n_cmp++; if (alu_ready !== 1'b0 || ld_ready !== 1'b0) begin n_err++; $display("FAIL cont_full_ready got alu=%b ld=%b want 0/0", alu_ready, ld_ready); end
        n_cmp++; if (pend_mask[7] !== 1'b1 || pend_mask[8] !== 1'b1) begin n_err++; $display("FAIL cont_pend got %h want bits 7,8 set", pend_mask); end
        alu_rd = 5'd3; alu_data = 32'hA3; ld_valid = 1'b0;
        tick(); if (w_en) got.push_back(wa3);
        n_cmp++; if (w_en !== 1'b1 || wa3 !== 5'd7 || wd3 !== 32'hB7) begin n_err++; $display("FAIL cont_load_first got %b/%0d/%h want 1/7/b7", w_en, wa3, wd3); end
        tick(); if (w_en) got.push_back(wa3);
        alu_valid = 1'b0;
        repeat (2) begin tick(); if (w_en) got.push_back(wa3); end
        n_cmp++; if (got.size() != 5) begin n_err++; $display("FAIL cont_count got %0d writes want 5", got.size()); end
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            n_cmp++; if (got[i] !== want[i]) begin n_err++; $display("FAIL cont_order[%0d] got %0d want %0d", i, got[i], want[i]); end
        end
    endtask

    task automatic test_x0();
        ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h1234;
        n_cmp++; if (ld_ready !== 1'b1) begin n_err++; $display("FAIL x0_ready got %b want 1", ld_ready); end
        tick();
        ld_valid = 1'b0;
        n_cmp++; if (pend_mask !== '0) begin n_err++; $display("FAIL x0_pend_buf got %h want 0", pend_mask); end
        tick();
        n_cmp++; if (w_en !== 1'b0 || wa3 !== 5'd0 || wd3 !== 32'h1234) begin n_err++; $display("FAIL x0_out got %b/%0d/%h want 0/0/1234", w_en, wa3, wd3); end
        n_cmp++; if (pend_mask !== '0) begin n_err++; $display("FAIL x0_pend_out got %h want 0", pend_mask); end
    endtask

    task automatic test_push_pop();
        ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h99;
        tick();
        ld_rd = 5'd10; ld_data = 32'h1010;
        tick();
        n_cmp++; if (w_en !== 1'b1 || wa3 !== 5'd9 || ld_ready !== 1'b1) begin n_err++; $display("FAIL pp_first got w_en=%b wa3=%0d ld_ready=%b want 1/9/1", w_en, wa3, ld_ready); end
        ld_rd = 5'd11; ld_data = 32'h1111;
        tick();
        n_cmp++; if (w_en !== 1'b1 || wa3 !== 5'd10 || wd3 !== 32'h1010 || ld_ready !== 1'b1) begin n_err++; $display("FAIL pp_wrap got %b/%0d/%h ld_ready=%b want 1/10/1010/1", w_en, wa3, wd3, ld_ready); end
        ld_valid = 1'b0;
        tick();
        n_cmp++; if (w_en !== 1'b1 || wa3 !== 5'd11 || wd3 !== 32'h1111) begin n_err++; $display("FAIL pp_last got %b/%0d/%h want 1/11/1111", w_en, wa3, wd3); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            alu_valid = $urandom_range(0, 1);
            alu_rd    = AW'($urandom_range(0, NR - 1));
            alu_data  = $urandom;
            ld_valid  = $urandom_range(0, 9) < 6;
            ld_rd     = AW'($urandom_range(0, NR - 1));
            ld_data   = $urandom;
            tick();
            n_cmp++; if (w_en !== m_wen || wa3 !== m_wa || wd3 !== m_wd) begin n_err++; $display("FAIL rnd_out@%0d got %b/%0d/%h want %b/%0d/%h", c, w_en, wa3, wd3, m_wen, m_wa, m_wd); end
            n_cmp++; if (byp_valid !== m_bv || byp_addr !== m_ba || byp_data !== m_bd) begin n_err++; $display("FAIL rnd_byp@%0d got %b/%0d/%h want %b/%0d/%h", c, byp_valid, byp_addr, byp_data, m_bv, m_ba, m_bd); end
            n_cmp++; if (pend_mask !== m_pend()) begin n_err++; $display("FAIL rnd_pend@%0d got %h want %h", c, pend_mask, m_pend()); end
            n_cmp++; if (ld_ready !== (q.size() < 2) || alu_ready !== (q.size() < 2)) begin n_err++; $display("FAIL rnd_ready@%0d got ld=%b alu=%b want %b", c, ld_ready, alu_ready, q.size() < 2); end
        end
    endtask

    task automatic test_mid_reset();
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h44; ld_valid = 1'b1; ld_rd = 5'd12; ld_data = 32'hC12;
        tick();
        alu_rd = 5'd5; alu_data = 32'h55; ld_rd = 5'd13; ld_data = 32'hC13;
        tick();
        alu_valid = 1'b0; ld_valid = 1'b0;
        n_cmp++; if (w_en !== 1'b1 || ld_ready !== 1'b0) begin n_err++; $display("FAIL mr_pre got w_en=%b ld_ready=%b want 1/0", w_en, ld_ready); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (w_en !== 1'b0 || pend_mask !== '0) begin n_err++; $display("FAIL mr_async got w_en=%b pend=%h want 0/0", w_en, pend_mask); end
        n_cmp++; if (ld_ready !== 1'b1 || alu_ready !== 1'b1) begin n_err++; $display("FAIL mr_count got ld=%b alu=%b want 1/1", ld_ready, alu_ready); end
        #2 rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (w_en !== 1'b0 || byp_valid !== 1'b0 || pend_mask !== '0) begin n_err++; $display("FAIL mr_stale@%0d got w_en=%b byp=%b pend=%h want 0/0/0", i, w_en, byp_valid, pend_mask); end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        test_reset();
        idle(3);
        test_alu_write();
        idle(3);
        test_contention();
        idle(3);
        test_x0();
        idle(3);
        test_push_pop();
        idle(3);
        test_random();
        idle(3);
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
